// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode/state encodings and sizing helper for alu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SLL    = 5'b00001,
        OP_SLT    = 5'b00010,
        OP_SLTU   = 5'b00011,
        OP_XOR    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_OR     = 5'b00110,
        OP_AND    = 5'b00111,
        OP_SUB    = 5'b01000,
        OP_SRA    = 5'b01101,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of operand bits that form a shift amount
    function automatic int shamt_w(input int xlen);
        return $clog2(xlen);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : One-bit-per-cycle shift-add multiplier and restoring divider.
//               Works on operand magnitudes and fixes signs on the way out.
//               fn = low three opcode bits (000 MUL .. 111 REMU).
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      fn,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = shamt_w(XLEN) + 1;

    logic            r_run;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi;      // product high half / partial remainder
    logic [XLEN-1:0] r_lo;      // multiplier bits / dividend-then-quotient
    logic [XLEN-1:0] r_m;       // multiplicand or divisor magnitude
    logic [2:0]      r_fn;
    logic            r_a_neg;
    logic            r_b_neg;

    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic [XLEN-1:0] w_hi_n;
    logic [XLEN-1:0] w_lo_n;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;

    // Operand sign decode and magnitudes captured at start
    always_comb begin
        w_a_signed = (fn == 3'b001) || (fn == 3'b010) || (fn == 3'b100) || (fn == 3'b110);
        w_b_signed = (fn == 3'b001) || (fn == 3'b100) || (fn == 3'b110);
        w_a_neg    = w_a_signed && a[XLEN-1];
        w_b_neg    = w_b_signed && b[XLEN-1];
        w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
        w_b_mag    = w_b_neg ? (~b + 1'b1) : b;
    end

    // One iteration of the multiply or divide datapath
    always_comb begin
        w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
        w_shift = {r_hi, r_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_m};
        if (!r_fn[2]) begin
            w_hi_n = w_sum[XLEN:1];
            w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
        end else if (!w_diff[XLEN]) begin
            w_hi_n = w_diff[XLEN-1:0];
            w_lo_n = {r_lo[XLEN-2:0], 1'b1};
        end else begin
            w_hi_n = w_shift[XLEN-1:0];
            w_lo_n = {r_lo[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and result select from the post-iteration values
    always_comb begin
        w_prod = {w_hi_n, w_lo_n};
        if (r_a_neg ^ r_b_neg) begin
            w_prod = ~w_prod + 1'b1;
        end
        w_quo = (r_a_neg ^ r_b_neg) ? (~w_lo_n + 1'b1) : w_lo_n;
        w_rem = r_a_neg ? (~w_hi_n + 1'b1) : w_hi_n;
        case (r_fn)
            3'b000:                 result = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result = w_quo;
            default:                result = w_rem;
        endcase
    end

    assign done = r_run && (r_cnt == CW'(XLEN - 1));

    // Iteration state: load on start, step once per cycle while running
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_m     <= '0;
            r_fn    <= '0;
            r_a_neg <= 1'b0;
            r_b_neg <= 1'b0;
        end else if (start) begin
            r_run   <= 1'b1;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= fn[2] ? w_a_mag : w_b_mag;
            r_m     <= fn[2] ? w_b_mag : w_a_mag;
            r_fn    <= fn;
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
        end else if (r_run) begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= done ? '0 : r_cnt + 1'b1;
            if (done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequential RV-style ALU. Base ops finish in one cycle; the
//               M-extension ops iterate for XLEN cycles in muldiv_iter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MULDIV_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] d1,
    input  logic [XLEN-1:0] d2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int              SHW       = shamt_w(XLEN);
    localparam bit              MD_ON     = (MULDIV_EN != 0);
    localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          r_state;
    state_e          w_next;
    logic            w_md_start;
    logic            w_load_base;
    logic            w_load_md;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic            w_use_md;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_base;
    logic            w_md_done;
    logic [XLEN-1:0] w_md_result;

    // Divide corner cases are answered directly instead of iterating
    always_comb begin
        w_div0    = (d2 == '0);
        w_ovf     = (d1 == C_MIN_NEG) && (d2 == '1);
        w_special = (op[4:2] == 3'b101) && (w_div0 || (w_ovf && !op[0]));
        w_use_md  = MD_ON && (op[4:3] == 2'b10) && !w_special;
        w_shamt   = d2[SHW-1:0];
    end

    // Single-cycle result for base, illegal and divide-corner opcodes
    always_comb begin
        w_base = '0;
        case (op_e'(op))
            OP_ADD:  w_base = d1 + d2;
            OP_SUB:  w_base = d1 - d2;
            OP_SLL:  w_base = d1 << w_shamt;
            OP_SLT:  w_base = {{(XLEN-1){1'b0}}, ($signed(d1) < $signed(d2))};
            OP_SLTU: w_base = {{(XLEN-1){1'b0}}, (d1 < d2)};
            OP_XOR:  w_base = d1 ^ d2;
            OP_SRL:  w_base = d1 >> w_shamt;
            OP_SRA:  w_base = $signed(d1) >>> w_shamt;
            OP_OR:   w_base = d1 | d2;
            OP_AND:  w_base = d1 & d2;
            OP_DIV:  if (MD_ON) w_base = w_div0 ? '1 : (w_ovf ? d1 : '0);
            OP_DIVU: if (MD_ON && w_div0) w_base = '1;
            OP_REM:  if (MD_ON && w_div0) w_base = d1;
            OP_REMU: if (MD_ON && w_div0) w_base = d1;
            default: w_base = '0;
        endcase
    end

    generate
        if (MD_ON) begin : g_muldiv
            muldiv_iter #(
                .XLEN   (XLEN)
            ) u_muldiv (
                .clk    (clk),
                .rst    (rst),
                .start  (w_md_start),
                .fn     (op[2:0]),
                .a      (d1),
                .b      (d2),
                .done   (w_md_done),
                .result (w_md_result)
            );
        end else begin : g_no_muldiv
            assign w_md_done   = 1'b0;
            assign w_md_result = '0;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath control
    always_comb begin
        w_next      = r_state;
        w_md_start  = 1'b0;
        w_load_base = 1'b0;
        w_load_md   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (w_use_md) begin
                        w_md_start = 1'b1;
                        w_next     = ST_CALC;
                    end else begin
                        w_load_base = 1'b1;
                        w_next      = ST_DONE;
                    end
                end
            end
            ST_CALC: begin
                if (w_md_done) begin
                    w_load_md = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Result register: loads on completion, otherwise holds
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else if (w_load_base) begin
            result <= w_base;
        end else if (w_load_md) begin
            result <= w_md_result;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
